// File: rtl/mac_sequencer.sv
// Dot-product sequencer: feeds operand pairs to an external 16x16 multiplier
// one pair per FETCH/MUL cycle pair and accumulates the products.
module mac_sequencer #(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [35:0]      mul_out,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [ACC_W-1:0] acc_r;
  logic [7:0]       cnt_r;
  logic             ovf_r;
  logic [15:0]      mul_a_r;
  logic [15:0]      mul_b_r;
  logic [ACC_W:0]   sum_s;

  // Extra top bit of the sum captures the accumulator carry-out.
  assign sum_s = {1'b0, acc_r} + {{(ACC_W-35){1'b0}}, mul_out};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (len == 8'd0) ? DONE : FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (in_valid) begin
          state_s = MUL;
        end else begin
          state_s = FETCH;
        end
      end
      MUL: begin
        if (cnt_r == 8'd1) begin
          state_s = DONE;
        end else begin
          state_s = FETCH;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand, count and accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= '0;
      cnt_r   <= 8'd0;
      ovf_r   <= 1'b0;
      mul_a_r <= 16'd0;
      mul_b_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= len;
            acc_r <= '0;
            ovf_r <= 1'b0;
          end
        end
        FETCH: begin
          if (in_valid) begin
            mul_a_r <= in_a;
            mul_b_r <= in_b;
          end
        end
        MUL: begin
          acc_r <= sum_s[ACC_W-1:0];
          ovf_r <= ovf_r | sum_s[ACC_W];
          cnt_r <= cnt_r - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    in_ready     = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state_r)
      IDLE:    busy = 1'b0;
      FETCH:   in_ready = 1'b1;
      MUL:     in_ready = 1'b0;
      DONE:    result_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign mul_a  = mul_a_r;
  assign mul_b  = mul_b_r;
  assign result = acc_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: two instances (ACC_W=40 and 36) share
// stimulus; table vectors, directed corner sequences and random jobs vs. a model.
module tb_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        result_ready;

  logic        in_ready40, result_valid40, busy40, ovf40;
  logic [15:0] mul_a40, mul_b40;
  logic [35:0] mul_out40;
  logic [39:0] result40;

  logic        in_ready36, result_valid36, busy36, ovf36;
  logic [15:0] mul_a36, mul_b36;
  logic [35:0] mul_out36;
  logic [35:0] result36;

  int checks = 0;
  int errors = 0;

  logic [15:0] op_a [256];
  logic [15:0] op_b [256];
  int          gap  [256];

  // Stand-ins for the external combinational multipliers
  assign mul_out40 = {4'd0, 32'(mul_a40) * 32'(mul_b40)};
  assign mul_out36 = {4'd0, 32'(mul_a36) * 32'(mul_b36)};

  mac_sequencer #(.ACC_W(40)) dut40 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready40), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a40), .mul_b(mul_b40), .mul_out(mul_out40),
    .result(result40), .result_valid(result_valid40), .result_ready(result_ready),
    .busy(busy40), .ovf(ovf40)
  );

  mac_sequencer #(.ACC_W(36)) dut36 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready36), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a36), .mul_b(mul_b36), .mul_out(mul_out36),
    .result(result36), .result_valid(result_valid36), .result_ready(result_ready),
    .busy(busy36), .ovf(ovf36)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_in_ready"}, 64'(in_ready40), 64'd0);
    check({nm, "_result_valid"}, 64'(result_valid40), 64'd0);
    check({nm, "_busy"}, 64'(busy40), 64'd0);
    check({nm, "_ovf"}, 64'(ovf40), 64'd0);
    check({nm, "_result"}, 64'(result40), 64'd0);
    check({nm, "_mul_a"}, 64'(mul_a40), 64'd0);
    check({nm, "_mul_b"}, 64'(mul_b40), 64'd0);
    check({nm, "_busy36"}, 64'(busy36), 64'd0);
  endtask

  // Whole job as plain arithmetic: sum of the first n products.
  function automatic longint unsigned model_sum(input int n);
    longint unsigned t;
    t = 64'd0;
    for (int i = 0; i < n; i++) t += 64'(op_a[i]) * 64'(op_b[i]);
    return t;
  endfunction

  // Runs one job on both DUTs; called at a negedge with both in IDLE.
  task automatic run_job(input string nm, input int n, input int rr_hold, input bit noise,
                         input int exp_lat, input logic [63:0] e40, input bit o40,
                         input logic [63:0] e36, input bit o36);
    int cyc, idx, gapcnt;
    bit done, accept;
    @(negedge clk);
    start = 1'b1; len = 8'(n); in_valid = 1'b0; result_ready = 1'b0;
    @(posedge clk);
    cyc = 1; idx = 0; gapcnt = (n > 0) ? gap[0] : 0; done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_rise"}, 64'(busy40), 64'd1);
    while (!done && cyc < 3000) begin
      if (result_valid40) begin
        done = 1'b1;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        len   = 8'($urandom);
        if (idx < n && gapcnt == 0) begin
          in_valid = 1'b1; in_a = op_a[idx]; in_b = op_b[idx];
        end else begin
          in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
          if (gapcnt > 0) gapcnt--;
        end
        accept = in_valid && in_ready40;
        @(posedge clk);
        cyc++;
        if (accept) begin
          idx++;
          gapcnt = (idx < n) ? gap[idx] : 0;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0; start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_result_valid expected=result_valid", nm);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      return;
    end
    if (exp_lat >= 0) check({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({nm, "_result40"}, 64'(result40), e40);
    check({nm, "_ovf40"}, 64'(ovf40), 64'(o40));
    check({nm, "_result36"}, 64'(result36), e36);
    check({nm, "_ovf36"}, 64'(ovf36), 64'(o36));
    check({nm, "_rv36"}, 64'(result_valid36), 64'd1);
    for (int k = 0; k < rr_hold; k++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      len   = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check({nm, "_hold_result"}, 64'(result40), e40);
      check({nm, "_hold_busy"}, 64'(busy40), 64'd1);
      check({nm, "_hold_rv"}, 64'(result_valid40), 64'd1);
    end
    // start coinciding with the DONE handshake must be dropped
    result_ready = 1'b1; start = 1'b1; len = 8'd7;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0; start = 1'b0;
    check({nm, "_post_busy"}, 64'(busy40), 64'd0);
    check({nm, "_post_rv"}, 64'(result_valid40), 64'd0);
    check({nm, "_post_result"}, 64'(result40), e40);
    check({nm, "_post_ovf36"}, 64'(ovf36), 64'(o36));
    @(posedge clk);
    @(negedge clk);
    check({nm, "_idle_busy"}, 64'(busy40), 64'd0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] a;
    logic [15:0] b;
    int          g;
    int          rr;
    bit          noise;
    int          lat;
    logic [63:0] e40;
    bit          o40;
    logic [63:0] e36;
    bit          o36;
  } vec_t;

  vec_t tbl [5];

  initial begin
    longint unsigned tot;
    int n;
    tbl[0] = '{1,   16'hFF00, 16'hFF00, 0, 0, 1'b0, 3,   64'hFE010000,   1'b0, 64'hFE010000,  1'b0};
    tbl[1] = '{0,   16'h0000, 16'h0000, 0, 1, 1'b0, 1,   64'h0,          1'b0, 64'h0,         1'b0};
    tbl[2] = '{255, 16'hFFFF, 16'hFFFF, 0, 1, 1'b0, 511, 64'hFEFE0200FF, 1'b0, 64'hEFE0200FF, 1'b1};
    tbl[3] = '{4,   16'h1234, 16'h0010, 1, 2, 1'b1, -1,  64'h48D00,      1'b0, 64'h48D00,     1'b0};
    tbl[4] = '{1,   16'h0003, 16'h0005, 0, 0, 1'b1, 3,   64'd15,         1'b0, 64'd15,        1'b0};

    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_a = 16'd0; in_b = 16'd0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Reset while a len=3 job sits in FETCH with a partial sum of 49
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midjob_in_ready", 64'(in_ready40), 64'd1);
    check("midjob_result", 64'(result40), 64'd49);
    rst = 1'b1;
    #1;
    check_idle_outputs("midjob_reset");
    @(negedge clk);
    rst = 1'b0;
    op_a[0] = 16'd3; op_b[0] = 16'd5; gap[0] = 0;
    run_job("fresh_after_reset", 1, 0, 1'b0, 3, 64'd15, 1'b0, 64'd15, 1'b0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 256; i++) begin
        op_a[i] = tbl[t].a; op_b[i] = tbl[t].b; gap[i] = tbl[t].g;
      end
      run_job($sformatf("tbl%0d", t), tbl[t].n, tbl[t].rr, tbl[t].noise, tbl[t].lat,
              tbl[t].e40, tbl[t].o40, tbl[t].e36, tbl[t].o36);
    end

    op_a[0] = 16'hFF00; op_b[0] = 16'hFF00; gap[0] = 0;
    op_a[1] = 16'hA54A; op_b[1] = 16'h7511; gap[1] = 0;
    run_job("two_pairs", 2, 0, 1'b0, 5, 64'd5529586666, 1'b0,
            64'd5529586666 % 64'h1000000000, 1'b0);

    for (int i = 0; i < 3; i++) begin
      op_a[i] = 16'(i + 1); op_b[i] = 16'(i + 1);
    end
    gap[0] = 0; gap[1] = 2; gap[2] = 5;
    run_job("stalls", 3, 4, 1'b0, -1, 64'd14, 1'b0, 64'd14, 1'b0);

    for (int i = 0; i < 5; i++) begin
      op_a[i] = 16'(i + 1); op_b[i] = 16'(i + 1); gap[i] = 0;
    end
    run_job("start_ignored", 5, 3, 1'b1, 11, 64'd55, 1'b0, 64'd55, 1'b0);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < 256; i++) begin
        op_a[i] = 16'($urandom); op_b[i] = 16'($urandom); gap[i] = $urandom_range(0, 3);
      end
      tot = model_sum(n);
      run_job($sformatf("rand%0d", r), n, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1,
              tot % (64'd1 << 40), (tot >> 40) != 64'd0,
              tot % (64'd1 << 36), (tot >> 36) != 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
